// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NREQ requesters, with bounded burst locking.
// Grants combinationally, registers the command onto the port and returns read data to the issuer.
module sram_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_sram,
  input  logic                 rst_sram,
  input  logic                 arb_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 sram_we,
  output logic                 sram_re,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_wdata,
  input  logic [DW-1:0]        sram_rdata,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]             gid_q, gid_d;
  logic [3:0]                 burst_q, burst_d;
  logic                       gnt_v_s;
  logic [IDW-1:0]             gnt_idx_s;
  logic [NREQ-1:0]            gnt_oh_s;
  logic [IDW-1:0]             next_ptr_s, pick_start_s;
  logic [IDW:0]               pick_s;
  logic                       sel_write_s;
  logic [AW-1:0]              sel_addr_s;
  logic [DW-1:0]              sel_wdata_s;
  logic                       sram_we_q, sram_re_q;
  logic [AW-1:0]              sram_addr_q;
  logic [DW-1:0]              sram_wdata_q;
  logic [RD_LAT-1:0]          pipe_v_q;
  logic [RD_LAT-1:0][IDW-1:0] pipe_id_q;
  logic [NREQ-1:0]            rsp_valid_q;
  logic [DW-1:0]              rsp_rdata_q;

  // Returns {found, index} of the first valid requester at or after start, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NREQ;
      if (valid[idx]) begin
        res = {1'b1, IDW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration: picks this cycle's winner and the next owner/pointer/burst state.
  always_comb begin
    next_ptr_s   = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
    pick_start_s = (state_q == ST_OWN) ? next_ptr_s : rr_ptr_q;
    pick_s       = rr_pick(req_valid, pick_start_s);
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    burst_d      = burst_q;
    gid_d        = gid_q;
    gnt_v_s      = 1'b0;
    gnt_idx_s    = gid_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_s[IDW]) begin
          gnt_v_s   = 1'b1;
          gnt_idx_s = pick_s[IDW-1:0];
          gid_d     = pick_s[IDW-1:0];
          burst_d   = 4'd1;
          state_d   = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!arb_en) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr_s;
        end else if (req_valid[gid_q] && (burst_q < 4'(MAX_BURST))) begin
          gnt_v_s   = 1'b1;
          gnt_idx_s = gid_q;
          burst_d   = burst_q + 4'd1;
        end else begin
          // Searching from owner+1 leaves the old owner as the last candidate.
          rr_ptr_d = next_ptr_s;
          if (pick_s[IDW]) begin
            gnt_v_s   = 1'b1;
            gnt_idx_s = pick_s[IDW-1:0];
            gid_d     = pick_s[IDW-1:0];
            burst_d   = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Winner's one-hot accept and its command fields.
  always_comb begin
    gnt_oh_s    = gnt_v_s ? (NREQ'(1'b1) << gnt_idx_s) : '0;
    sel_write_s = req_write[gnt_idx_s];
    sel_addr_s  = req_addr[gnt_idx_s*AW +: AW];
    sel_wdata_s = req_wdata[gnt_idx_s*DW +: DW];
  end

  // Arbiter state registers.
  always_ff @(posedge clk_sram) begin
    if (rst_sram) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      burst_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      burst_q  <= burst_d;
    end
  end

  // SRAM command register, read-tracking pipeline and response register.
  always_ff @(posedge clk_sram) begin
    if (rst_sram) begin
      sram_we_q    <= 1'b0;
      sram_re_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      pipe_v_q     <= '0;
      pipe_id_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      sram_we_q <= gnt_v_s & sel_write_s;
      sram_re_q <= gnt_v_s & ~sel_write_s;
      if (gnt_v_s) begin
        sram_addr_q  <= sel_addr_s;
        sram_wdata_q <= sel_wdata_s;
      end
      pipe_v_q[0]  <= gnt_v_s & ~sel_write_s;
      pipe_id_q[0] <= gnt_idx_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]  <= pipe_v_q[i-1];
        pipe_id_q[i] <= pipe_id_q[i-1];
      end
      rsp_valid_q <= pipe_v_q[RD_LAT-1] ? (NREQ'(1'b1) << pipe_id_q[RD_LAT-1]) : '0;
      if (pipe_v_q[RD_LAT-1]) begin
        rsp_rdata_q <= sram_rdata;
      end
    end
  end

  assign req_ready  = gnt_oh_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_we    = sram_we_q;
  assign sram_re    = sram_re_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q == ST_OWN) | (|pipe_v_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model with a response queue.
module tb_sram_port_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MB   = 4;
  localparam int RDL  = 1;

  logic                clk_sram = 1'b0;
  logic                rst_sram;
  logic                arb_en;
  logic [NREQ-1:0]     req_valid, req_write;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                sram_we, sram_re;
  logic [AW-1:0]       sram_addr;
  logic [DW-1:0]       sram_wdata, sram_rdata;
  logic [0:0]          grant_id;
  logic                busy;

  always #5 clk_sram = ~clk_sram;

  sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB), .RD_LAT(RDL)) u_dut (
    .clk_sram(clk_sram), .rst_sram(rst_sram), .arb_en(arb_en),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .grant_id(grant_id), .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM with read data presented in the strobe cycle (RD_LAT = 1).
  logic [DW-1:0] smem [256];
  logic          mem_clear;
  always @(posedge clk_sram) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
    end else if (sram_we) begin
      smem[sram_addr] <= sram_wdata;
    end
  end
  assign sram_rdata = sram_re ? smem[sram_addr] : 32'hBADC_0FFE;

  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t           rq[$];
  logic [DW-1:0]  m_mem [256];
  bit             m_own, m_we, m_re;
  int             m_ptr, m_owner, m_cnt;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata, m_rdata;
  int             cyc, n_checks, n_errors;
  logic [1:0]     burst_exp [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                                     2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] vv, input int start);
    for (int k = 0; k < NREQ; k++) if (vv[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic drive(input bit en, input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    arb_en    = en;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // One clock: compare all outputs against the model at negedge, then advance the model.
  task automatic step_cycle();
    int g, n_ptr, n_cnt;
    bit n_own;
    logic [NREQ-1:0] exp_rv;
    @(negedge clk_sram);
    g = -1; n_own = m_own; n_ptr = m_ptr; n_cnt = m_cnt;
    if (!m_own) begin
      if (arb_en) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) begin n_own = 1; n_cnt = 1; end
      end
    end else if (!arb_en) begin
      n_own = 0; n_ptr = (m_owner + 1) % NREQ;
    end else if (req_valid[m_owner] && m_cnt < MB) begin
      g = m_owner; n_cnt = m_cnt + 1;
    end else begin
      n_ptr = (m_owner + 1) % NREQ;
      g = pick(req_valid, n_ptr);
      if (g < 0) n_own = 0; else n_cnt = 1;
    end
    chk_eq("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    chk_eq("sram_we", sram_we, m_we);
    chk_eq("sram_re", sram_re, m_re);
    chk_eq("sram_addr", sram_addr, m_addr);
    chk_eq("sram_wdata", sram_wdata, m_wdata);
    chk_eq("grant_id", grant_id, m_owner);
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv  = NREQ'(1 << rq[0].id);
      m_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk_eq("rsp_valid", rsp_valid, exp_rv);
    chk_eq("rsp_rdata", rsp_rdata, m_rdata);
    chk_eq("busy", busy, m_own || rq.size() > 0);
    if (rst_sram) begin
      m_own = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_we = 0; m_re = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      rq.delete();
    end else begin
      m_own = n_own; m_ptr = n_ptr; m_cnt = n_cnt; m_we = 0; m_re = 0;
      if (g >= 0) begin
        m_owner = g;
        m_addr  = req_addr[g*AW +: AW];
        m_wdata = req_wdata[g*DW +: DW];
        if (req_write[g]) begin
          m_we = 1;
          m_mem[m_addr] = m_wdata;
        end else begin
          m_re = 1;
          rq.push_back('{cyc + 1 + RDL, g, m_mem[m_addr]});
        end
      end
    end
    cyc++;
    @(posedge clk_sram);
    #1;
  endtask

  task automatic do_reset();
    rst_sram = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    step_cycle();
    rst_sram = 1'b0;
  endtask

  initial begin
    logic [1:0] rv;
    bit         rr;
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    n_checks = 0; n_errors = 0; cyc = 0;
    m_own = 0; m_we = 0; m_re = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    rv = 2'b00;
    mem_clear = 1'b1;
    rst_sram  = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    @(posedge clk_sram);
    #1;
    step_cycle();
    mem_clear = 1'b0;
    rst_sram  = 1'b0;
    chk_eq("rst_strobes", {sram_we, sram_re}, 2'b00);
    chk_eq("rst_gid", grant_id, 1'b0);

    // Single read of 0xDEADBEEF at 0x10 (written first through requester 0).
    drive(1'b1, 2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0);
    step_cycle();
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    step_cycle();
    drive(1'b1, 2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
    #1 chk_eq("sr_ready", req_ready, 2'b01);
    step_cycle();
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk_eq("sr_cmd", {sram_we, sram_re, sram_addr}, {1'b0, 1'b1, 8'h10});
    step_cycle();
    chk_eq("sr_rsp", {rsp_valid, rsp_rdata}, {2'b01, 32'hDEADBEEF});
    step_cycle();

    // Burst lock with both requesters streaming.
    do_reset();
    drive(1'b1, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1 chk_eq("burst_seq", req_ready, burst_exp[i]);
      step_cycle();
    end

    // Owner drop after two grants, then burst restart and lone requester.
    do_reset();
    drive(1'b1, 2'b10, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
    step_cycle();
    step_cycle();
    drive(1'b1, 2'b01, 2'b00, 8'h21, 8'h20, 32'h0, 32'h0);
    #1 chk_eq("drop_ready", req_ready, 2'b01);
    step_cycle();
    drive(1'b1, 2'b11, 2'b00, 8'h21, 8'h20, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk_eq("drop_burst", req_ready, (i < 3) ? 2'b01 : 2'b10);
      step_cycle();
    end
    drive(1'b1, 2'b10, 2'b00, 8'h21, 8'h20, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1 chk_eq("lone_ready", req_ready, 2'b10);
      step_cycle();
    end

    // Write then queued read of the same address.
    do_reset();
    drive(1'b1, 2'b11, 2'b01, 8'h03, 8'h03, 32'hA5A5A5A5, 32'h0);
    #1 chk_eq("mix_wr_first", req_ready, 2'b01);
    step_cycle();
    drive(1'b1, 2'b10, 2'b00, 8'h03, 8'h03, 32'h0, 32'h0);
    #1 chk_eq("mix_rd_ready", req_ready, 2'b10);
    chk_eq("mix_we", {sram_we, sram_re}, 2'b10);
    step_cycle();
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk_eq("mix_re", {sram_we, sram_re}, 2'b01);
    step_cycle();
    chk_eq("mix_rsp", {rsp_valid, rsp_rdata}, {2'b10, 32'hA5A5A5A5});
    step_cycle();

    // arb_en low with an in-flight read.
    do_reset();
    drive(1'b1, 2'b01, 2'b00, 8'h05, 8'h00, 32'h0, 32'h0);
    step_cycle();
    drive(1'b0, 2'b11, 2'b00, 8'h06, 8'h07, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1 chk_eq("en_low_ready", req_ready, 2'b00);
      step_cycle();
      if (i == 0) chk_eq("en_low_rsp", {rsp_valid, rsp_rdata}, {2'b01, init_word(5)});
    end
    chk_eq("en_low_busy", busy, 1'b0);

    // Reset while a read is in flight.
    do_reset();
    drive(1'b1, 2'b01, 2'b00, 8'h07, 8'h00, 32'h0, 32'h0);
    step_cycle();
    rst_sram = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    chk_eq("rmr_re", sram_re, 1'b1);
    step_cycle();
    rst_sram = 1'b0;
    chk_eq("rmr_cmd", {sram_we, sram_re, sram_addr, grant_id, busy}, 12'h000);
    chk_eq("rmr_data", {sram_wdata, rsp_rdata}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk_eq("rmr_no_rsp", rsp_valid, 2'b00);
      step_cycle();
    end
    drive(1'b1, 2'b11, 2'b00, 8'h08, 8'h09, 32'h0, 32'h0);
    #1 chk_eq("rmr_next", req_ready, 2'b01);
    step_cycle();

    // Randomized traffic on a small address window to create read-after-write hits.
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) rv = 2'($urandom);
      rst_sram = rr;
      drive($urandom_range(0, 9) != 0, rr ? 2'b00 : rv, 2'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom, $urandom);
      step_cycle();
    end
    rst_sram = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step_cycle();
    chk_eq("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Round-robin arbiter that shares the single SRAM port between NREQ requesters on the SRAM clock domain.
- Typical requesters: the address/write FIFO drain path and a second master such as a DMA or scrubber.
- Grants at most one access per cycle and registers the command onto the SRAM port.
- Routes read data back to the issuing requester after the fixed SRAM read latency.
- Supports bounded burst locking so a streaming requester keeps the port for up to MAX_BURST consecutive accesses.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 8, SRAM address width
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive grants to one owner before rotation (1..15)
- RD_LAT, 1, cycles from sram_re asserted to sram_rdata valid (1..4)

Ports:
- clk_sram  in  1  SRAM clock, sole clock
- rst_sram  in  1  synchronous, active-high reset
- arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight reads complete
- req_valid  in  NREQ  per-requester access request
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot read-data valid
- rsp_rdata  out  DW  read data, valid with rsp_valid
- sram_we  out  1  registered write strobe
- sram_re  out  1  registered read strobe
- sram_addr  out  AW  registered address
- sram_wdata  out  DW  registered write data
- sram_rdata  in  DW  SRAM read data
- grant_id  out  log2(NREQ) (min 1)  current/last owner index
- busy  out  1  FSM in OWN, or any read in flight

Behaviour:
- Reset (rst_sram=1 at clock edge) clears everything:
  - FSM = IDLE; rr_ptr = 0; burst_cnt = 0; grant_id = 0.
  - req_ready, rsp_valid, sram_we, sram_re all 0; sram_addr, sram_wdata, rsp_rdata = 0.
  - Read tracking pipeline is cleared, so reads in flight at reset are dropped and produce no rsp_valid.
- Grant is combinational from the current state and req_valid. req_ready is asserted in the same cycle N as the accepted request.
- SRAM command appears on sram_* at cycle N+1, for exactly one cycle. sram_we and sram_re are never both 1.
- Cycles with no grant: sram_we = sram_re = 0; sram_addr and sram_wdata hold their last values.
- Read tracking: a shift register of depth RD_LAT carries {valid, id}. For a read accepted at N:
  - rsp_valid[id] = 1 at cycle N+1+RD_LAT, registered;
  - rsp_rdata captures sram_rdata at that point.
- Response ordering equals grant order. There is no response back-pressure; requesters must always accept responses.
- FSM states: IDLE, OWN.
- IDLE:
  - If arb_en and any req_valid: winner = first valid index searched from rr_ptr upward, wrapping modulo NREQ.
  - Grant the winner; grant_id = winner; burst_cnt = 1; go to OWN.
  - Otherwise stay in IDLE.
- OWN:
  - arb_en = 0: no grant; go to IDLE; rr_ptr = grant_id+1 mod NREQ.
  - req_valid[grant_id] = 1 and burst_cnt < MAX_BURST: grant the owner again; burst_cnt++.
  - Otherwise rotate:
    - rr_ptr = grant_id+1 mod NREQ.
    - Search from rr_ptr; the old owner is considered last.
    - If a winner is found, grant it in the same cycle (no bubble); grant_id = winner; burst_cnt = 1; stay in OWN.
    - If none is found, go to IDLE.
- Boundary cases:
  - MAX_BURST = 1 gives pure round-robin.
  - A lone requester is granted every cycle indefinitely. burst_cnt resets to 1 at each MAX_BURST boundary and never overflows.
  - Deasserting req_valid while it is the owner forfeits ownership that cycle.
  - Address and write data are sampled only in the grant cycle. Changing them while unaccepted has no effect.
- busy = (FSM == OWN) | (any valid bit in the read tracking pipeline).

Test Plan:
- Single read:
  - Stimulus: req 0 reads addr 0x10; SRAM returns 0xDEADBEEF; RD_LAT = 1.
  - Required: req_ready[0] at cycle N; sram_re = 1, sram_addr = 0x10 at N+1; rsp_valid = 2'b01, rsp_rdata = 0xDEADBEEF at N+2.
- Burst lock:
  - Stimulus: NREQ = 2, MAX_BURST = 4; both requesters hold req_valid for 12 cycles.
  - Required: grant sequence 0,0,0,0,1,1,1,1,0,0,0,0 with no idle cycle.
- Owner drop:
  - Stimulus: req 1 owns the port with burst_cnt = 2, deasserts req_valid; req 0 is valid.
  - Required: req 0 is granted that same cycle; burst_cnt = 1.
- Mixed traffic:
  - Stimulus: req 0 writes 0xA5A5A5A5 to addr 0x03 while req 1 reads 0x03 queued behind it.
  - Required: write issued first; req 1 receives 0xA5A5A5A5 with rsp_valid = 2'b10.
- arb_en low:
  - Stimulus: arb_en = 0 with both requesters valid for 5 cycles.
  - Required: req_ready stays 0; in-flight read still returns; busy falls once the pipeline is empty.
- Reset mid-read:
  - Stimulus: rst_sram pulsed one cycle after sram_re.
  - Required: no rsp_valid ever; all outputs at reset values; next grant goes to req 0.
